// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the byte-serial program loader.
// The word layout matches the CPU's opcode/WA/RA1/RA2/imm field split.
package prog_loader_pkg;

  localparam int WORD_W         = 24;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 3;

  // Frame field constants: a count of zero is never a legal frame.
  localparam logic [BYTE_W-1:0] MIN_COUNT  = 8'd1;
  localparam logic [1:0]        LAST_PHASE = 2'(BYTES_PER_WORD - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT,
    ST_PAYLOAD,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_t;

endpackage

// File: rtl/word_packer.sv
// Packs three stream bytes MSB first into one instruction word and pulses
// word_ready in the cycle after the third byte is shifted in.
module word_packer
  import prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              shift_en,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word,
  output logic              word_ready,
  output logic              last_byte
);

  logic [1:0] phase_q;

  assign last_byte = (phase_q == LAST_PHASE);

  always_ff @(posedge clk) begin
    if (reset) begin
      word       <= '0;
      phase_q    <= 2'd0;
      word_ready <= 1'b0;
    end else begin
      word_ready <= shift_en && last_byte;
      if (clear) begin
        phase_q <= 2'd0;
      end else if (shift_en) begin
        word    <= {word[WORD_W-BYTE_W-1:0], byte_in};
        phase_q <= last_byte ? 2'd0 : phase_q + 2'd1;
      end
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Frame receiver: count, 3*N payload bytes, XOR checksum. Writes packed words
// to instruction memory and holds the CPU in reset until a verified load.
//
// Byte handshake: a byte transfers on a rising edge where byte_valid and
// byte_ready are both high; byte_ready is registered and does not depend on
// byte_valid, and byte_data is ignored on any other edge.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error,
  output logic [2:0]        state_dbg
);

  localparam int DEPTH = 1 << ADDR_W;

  state_t      state_q, state_d;
  logic [7:0]  n_q;
  logic [7:0]  word_cnt_q;
  logic [7:0]  csum_q;
  logic        accept;
  logic        count_bad;
  logic        last_byte;
  logic        load_count;
  logic        load_payload;

  assign accept       = byte_valid && byte_ready;
  assign count_bad    = (byte_data < MIN_COUNT) || (int'(byte_data) > DEPTH);
  assign load_count   = (state_q == ST_COUNT) && accept;
  assign load_payload = (state_q == ST_PAYLOAD) && accept;
  assign state_dbg    = state_q;

  word_packer u_packer (
    .clk        (CLK),
    .reset      (reset),
    .clear      (load_count),
    .shift_en   (load_payload),
    .byte_in    (byte_data),
    .word       (imem_wdata),
    .word_ready (imem_we),
    .last_byte  (last_byte)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_COUNT;
      ST_COUNT:   if (accept) state_d = count_bad ? ST_ERROR : ST_PAYLOAD;
      ST_PAYLOAD: if (accept && last_byte && (word_cnt_q + 8'd1 == n_q)) state_d = ST_CHECK;
      ST_CHECK:   if (accept) state_d = (byte_data == csum_q) ? ST_DONE : ST_ERROR;
      ST_DONE:    if (start) state_d = ST_COUNT;
      ST_ERROR:   if (start) state_d = ST_COUNT;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      byte_ready <= 1'b0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      n_q        <= '0;
      word_cnt_q <= '0;
      csum_q     <= '0;
      imem_waddr <= '0;
    end else begin
      state_q    <= state_d;
      byte_ready <= state_d inside {ST_COUNT, ST_PAYLOAD, ST_CHECK};
      cpu_reset  <= (state_d != ST_DONE);
      done       <= (state_d == ST_DONE);
      error      <= (state_d == ST_ERROR);
      if (load_count) begin
        n_q        <= byte_data;
        word_cnt_q <= '0;
        csum_q     <= byte_data;
        imem_waddr <= '0;
      end else begin
        if (load_payload) begin
          csum_q <= csum_q ^ byte_data;
          if (last_byte) word_cnt_q <= word_cnt_q + 8'd1;
        end
        // Step past the strobed address, but never past the frame's last word.
        if (imem_we && (word_cnt_q != n_q)) imem_waddr <= imem_waddr + 1'b1;
      end
    end
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Byte-serial program loader that sits directly upstream of the CPU's instruction memory. It receives a framed byte stream (count, payload, checksum), packs every 3 bytes into one 24-bit instruction word, and writes the words into instruction memory at consecutive addresses. It holds the CPU in reset while loading and releases it only after a complete, checksum-verified load.

## Interface
- ADDR_W, 8, instruction-memory address width; DEPTH = 2**ADDR_W words
- WORD_W, 24, instruction width; fixed to match the CPU field split opcode[23:20], WA[19:16], RA1[15:12], RA2[11:8], imm[7:0]

One clock; reset is synchronous and active-high.

- CLK  input  1  clock; all state changes on rising edge
- reset  input  1  synchronous, active-high
- start  input  1  request a (re)load; sampled in IDLE, DONE and ERROR, ignored elsewhere
- byte_valid  input  1  byte_data holds a valid byte
- byte_data  input  8  stream byte
- byte_ready  output  1  loader can accept a byte this cycle
- imem_we  output  1  one-cycle write strobe to instruction memory
- imem_waddr  output  ADDR_W  write address
- imem_wdata  output  WORD_W  write data
- cpu_reset  output  1  reset to the CPU; high except in DONE
- done  output  1  high in DONE
- error  output  1  high in ERROR

## Operation
- Byte accepted iff byte_valid & byte_ready at a rising edge; no acceptance otherwise, byte_data don't-care.
- Frame: count byte N, then 3·N payload bytes MSB first (byte 0 → [23:16], byte 1 → [15:8], byte 2 → [7:0]), then checksum byte C.
- C must equal XOR of N and all payload bytes.
- States: IDLE, COUNT, PAYLOAD, CHECK, DONE, ERROR.
- IDLE: byte_ready=0; start → COUNT.
- COUNT: byte_ready=1; on accept, N=0 or N>DEPTH → ERROR; else latch N, clear word counter, byte phase and address, seed checksum with N → PAYLOAD.
- PAYLOAD: byte_ready=1; each accept shifts byte into packer, XORs into checksum, advances phase 0→1→2→0. When phase 2 is accepted: word written (see Timing), address and word counter increment; if that word is number N → CHECK.
- CHECK: byte_ready=1; on accept, match → DONE, mismatch → ERROR.
- DONE: cpu_reset=0, done=1, byte_ready=0; start → COUNT.
- ERROR: error=1, cpu_reset=1, byte_ready=0; start → COUNT. Words already written stay in memory; no rollback.
- start outside IDLE/DONE/ERROR is ignored; no abort mid-frame except reset.
- Address never wraps: N≤DEPTH guarantees the last write is at DEPTH-1 at most.

## Timing
- Reset values: state IDLE, byte_ready 0, imem_we 0, imem_waddr 0, imem_wdata 0, cpu_reset 1, done 0, error 0, counters and checksum 0.
- All outputs registered.
- start sampled at edge k → COUNT in cycle k+1, byte_ready=1 from k+1; in DONE, cpu_reset and done switch back at k+1.
- imem_we high exactly one cycle, in the cycle after the phase-2 byte is accepted; imem_waddr/imem_wdata valid in that same cycle. Address increments after the strobe.
- Back-to-back bytes (byte_valid held high) sustain 1 byte/cycle; no bubbles required by the loader.
- Checksum accept at edge k → done/error and cpu_reset change in cycle k+1. Last imem_we precedes or coincides with CHECK; the CPU never leaves reset before its final word is written.
- Reset mid-frame: return to IDLE next cycle with reset values; partial word discarded, no write strobe.

## Structure
- Package prog_loader_pkg: state enum type, WORD_W=24, BYTES_PER_WORD=3, frame field constants.
- One sub-module, word_packer: 3-byte shift register plus phase counter; outputs packed word and word_ready pulse. The FSM, counters, checksum and output registers live in prog_loader.

## Test plan
- Frame 02,41,20,05,10,00,07,71 streamed back-to-back after start → writes 0x412005 @0, 0x100007 @1; done=1, cpu_reset=0 one cycle after checksum byte.
- Same frame with checksum 0x70 → both words written, error=1, cpu_reset stays 1, done=0; start then the correct frame → DONE.
- Count byte 00 (and, with ADDR_W=2, count 05) → ERROR immediately, no imem_we pulse.
- Same valid frame with byte_valid toggling randomly → identical writes and final state; no byte lost or duplicated.
- reset asserted after 4 payload bytes → IDLE next cycle, all outputs at reset values, no strobe for the partial word; subsequent full load succeeds.
- start held high during PAYLOAD → ignored; with ADDR_W=2, N=4 → last write at address 3, no wrap.
